// File: rtl/bf_sequencer.sv
// bf_sequencer: run-control sequencer for the brainfuck core.
// Loads a length-prefixed program from the host byte link into code RAM,
// zeroes the whole tape RAM, then releases the core from reset until it
// reaches end-of-program or the cycle budget, and parks it in reset again.
//
// Ports:
//   clk, resetq              system clock, asynchronous active-low reset
//   start                    load request pulse (honoured in IDLE/DONE only)
//   rx_valid/rx_data/rx_ready host byte stream handshake
//   code_we/waddr/wdata      code RAM write port (combinational from handshake)
//   core_resetq              registered active-low reset to the core
//   core_code_addr           core next-pc, compared against program length
//   core_mem_*               core tape port, forwarded only while running
//   tape_addr/wr/dout        tape RAM write port (clear engine or core)
//   run_limit                cycle budget, 0 = unlimited, captured on RUN entry
//   busy/done/timeout/cycles run status
module bf_sequencer #(
  parameter int unsigned CADDR_WIDTH = 13,
  parameter int unsigned DADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   resetq,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   code_we,
  output logic [CADDR_WIDTH-1:0] code_waddr,
  output logic [7:0]             code_wdata,
  output logic                   core_resetq,
  input  logic [CADDR_WIDTH-1:0] core_code_addr,
  input  logic [DADDR_WIDTH-1:0] core_mem_addr,
  input  logic                   core_mem_wr,
  input  logic [DATA_WIDTH-1:0]  core_mem_dout,
  output logic [DADDR_WIDTH-1:0] tape_addr,
  output logic                   tape_wr,
  output logic [DATA_WIDTH-1:0]  tape_dout,
  input  logic [31:0]            run_limit,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [31:0]            cycles
);

  localparam int unsigned MAXLEN = (32'd1 << CADDR_WIDTH) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_LOAD, S_CLEAR, S_RUN, S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [7:0]             r_len_lo;
  logic [15:0]            r_raw_len;
  logic [CADDR_WIDTH-1:0] r_clen;
  logic [15:0]            r_cnt;
  logic [DADDR_WIDTH-1:0] r_clr;
  logic [31:0]            r_limit;
  logic [31:0]            r_cycles;
  logic                   r_timeout;
  logic                   r_core_resetq;

  logic [15:0]            w_len_in;
  logic                   w_load_hs;
  logic                   w_last_byte;
  logic                   w_clr_last;
  logic                   w_prog_end;
  logic                   w_limit_hit;
  logic [31:0]            w_cyc_inc;

  assign w_len_in    = {rx_data, r_len_lo};
  assign w_load_hs   = (r_state == S_LOAD) && rx_valid;
  // The raw 16-bit length counts bytes to consume, even past the clamp.
  assign w_last_byte = w_load_hs && (r_cnt == r_raw_len - 16'd1);
  assign w_clr_last  = (r_clr == '1);
  assign w_cyc_inc   = (r_cycles == '1) ? r_cycles : r_cycles + 32'd1;
  assign w_prog_end  = (core_code_addr == r_clen);
  // Compare against the post-increment count so RUN lasts exactly run_limit cycles.
  assign w_limit_hit = (r_limit != '0) && (w_cyc_inc == r_limit);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    rx_ready  = 1'b0;
    tape_addr = '0;
    tape_wr   = 1'b0;
    tape_dout = '0;
    unique case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_LEN0;
      S_LEN0: begin
        rx_ready = 1'b1;
        if (rx_valid) w_next = S_LEN1;
      end
      S_LEN1: begin
        rx_ready = 1'b1;
        if (rx_valid) w_next = (w_len_in == 16'd0) ? S_CLEAR : S_LOAD;
      end
      S_LOAD: begin
        rx_ready = 1'b1;
        if (w_last_byte) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        tape_addr = r_clr;
        tape_wr   = 1'b1;
        if (w_clr_last) w_next = (r_clen == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        tape_addr = core_mem_addr;
        tape_wr   = core_mem_wr;
        tape_dout = core_mem_dout;
        if (w_prog_end || w_limit_hit) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_len_lo      <= '0;
      r_raw_len     <= '0;
      r_clen        <= '0;
      r_cnt         <= '0;
      r_clr         <= '0;
      r_limit       <= '0;
      r_cycles      <= '0;
      r_timeout     <= 1'b0;
      r_core_resetq <= 1'b0;
    end else begin
      r_core_resetq <= (w_next == S_RUN);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_timeout <= 1'b0;
            r_cnt     <= '0;
          end
        end
        S_LEN0: if (rx_valid) r_len_lo <= rx_data;
        S_LEN1: begin
          if (rx_valid) begin
            r_raw_len <= w_len_in;
            r_clen    <= (32'(w_len_in) > MAXLEN) ? '1 : CADDR_WIDTH'(w_len_in);
            r_cnt     <= '0;
          end
        end
        S_LOAD: if (rx_valid) r_cnt <= r_cnt + 16'd1;
        S_CLEAR: begin
          r_clr <= r_clr + 1'b1;
          // Cleared on every CLEAR exit so a zero-length load reports 0 cycles.
          if (w_clr_last) begin
            r_cycles <= '0;
            r_limit  <= run_limit;
          end
        end
        S_RUN: begin
          r_cycles <= w_cyc_inc;
          if (w_next == S_DONE) r_timeout <= !w_prog_end;
        end
        default: ;
      endcase
    end
  end

  assign code_we     = w_load_hs && (32'(r_cnt) < 32'(r_clen));
  assign code_waddr  = code_we ? CADDR_WIDTH'(r_cnt) : '0;
  assign code_wdata  = code_we ? rx_data : '0;
  assign core_resetq = r_core_resetq;
  assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done        = (r_state == S_DONE);
  assign timeout     = r_timeout;
  assign cycles      = r_cycles;

endmodule

// File: tb/tb_bf_sequencer.sv
// Self-checking bench for bf_sequencer (reduced address widths keep the
// tape clear short). A table of hand-derived runs is followed by random runs
// whose outcome comes from a trace-based reference model.
module tb_bf_sequencer;

  localparam int unsigned CW     = 8;
  localparam int unsigned DW     = 6;
  localparam int unsigned DTW    = 8;
  localparam int unsigned MAXLEN = (1 << CW) - 1;
  localparam int unsigned DEPTH  = 1 << DW;

  logic           clk = 1'b0;
  logic           resetq, start, rx_valid;
  logic [7:0]     rx_data;
  logic           rx_ready, code_we;
  logic [CW-1:0]  code_waddr;
  logic [7:0]     code_wdata;
  logic           core_resetq;
  logic [CW-1:0]  core_code_addr;
  logic [DW-1:0]  core_mem_addr;
  logic           core_mem_wr;
  logic [DTW-1:0] core_mem_dout;
  logic [DW-1:0]  tape_addr;
  logic           tape_wr;
  logic [DTW-1:0] tape_dout;
  logic [31:0]    run_limit;
  logic           busy, done, timeout;
  logic [31:0]    cycles;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned trace[$];

  typedef struct {
    logic [15:0] len;
    logic [31:0] limit;
    int          mode;     // 0 straight-line pc, 1 loop below length, 2 random pc
    int          gap;      // percent of idle rx cycles
    bit          sil;      // pulse start during load
    bit          rir;      // hold rx_valid during run
    int          abort;    // 0 none, 1 LOAD, 2 CLEAR, 3 RUN
    bit          exp_to;
    int unsigned exp_cyc;
  } vec_t;

  bf_sequencer #(.CADDR_WIDTH(CW), .DADDR_WIDTH(DW), .DATA_WIDTH(DTW)) dut (
    .clk(clk), .resetq(resetq), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .code_we(code_we), .code_waddr(code_waddr), .code_wdata(code_wdata),
    .core_resetq(core_resetq), .core_code_addr(core_code_addr),
    .core_mem_addr(core_mem_addr), .core_mem_wr(core_mem_wr), .core_mem_dout(core_mem_dout),
    .tape_addr(tape_addr), .tape_wr(tape_wr), .tape_dout(tape_dout),
    .run_limit(run_limit), .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_core();
    core_mem_addr = DW'($urandom);
    core_mem_wr   = 1'($urandom);
    core_mem_dout = DTW'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".rx_ready"},    32'(rx_ready),    32'(0));
    chk({tag, ".code_we"},     32'(code_we),     32'(0));
    chk({tag, ".code_waddr"},  32'(code_waddr),  32'(0));
    chk({tag, ".code_wdata"},  32'(code_wdata),  32'(0));
    chk({tag, ".core_resetq"}, 32'(core_resetq), 32'(0));
    chk({tag, ".tape_addr"},   32'(tape_addr),   32'(0));
    chk({tag, ".tape_wr"},     32'(tape_wr),     32'(0));
    chk({tag, ".tape_dout"},   32'(tape_dout),   32'(0));
    chk({tag, ".busy"},        32'(busy),        32'(0));
    chk({tag, ".done"},        32'(done),        32'(0));
    chk({tag, ".timeout"},     32'(timeout),     32'(0));
    chk({tag, ".cycles"},      cycles,           32'(0));
  endtask

  task automatic do_abort(input string tag);
    @(negedge clk);
    resetq = 1'b0; start = 1'b0; rx_valid = 1'b1; rx_data = 8'($urandom);
    rand_core();
    #1 check_reset_vals({tag, ".rst"});
    @(negedge clk);
    #1 check_reset_vals({tag, ".rst_hold"});
    resetq = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, ".post.busy"},     32'(busy),        32'(0));
    chk({tag, ".post.done"},     32'(done),        32'(0));
    chk({tag, ".post.rx_ready"}, 32'(rx_ready),    32'(0));
    chk({tag, ".post.core_rst"}, 32'(core_resetq), 32'(0));
  endtask

  function automatic int unsigned clamp_len(input logic [15:0] len);
    return (32'(len) > MAXLEN) ? MAXLEN : 32'(len);
  endfunction

  // pc the core presents in each RUN cycle; long enough to cover the run.
  function automatic void build_trace(input int mode, input int unsigned clen,
                                      input logic [31:0] limit);
    int unsigned n;
    n = (limit != 0) ? limit : clen + 1;
    trace.delete();
    for (int unsigned t = 0; t < n; t++) begin
      case (mode)
        1:       trace.push_back((clen == 0) ? 0 : t % clen);
        2:       trace.push_back($urandom_range(clen, 0));
        default: trace.push_back(t);
      endcase
    end
  endfunction

  // Run length is the first cycle where pc equals the length, else the budget.
  function automatic void model(input int unsigned clen, input logic [31:0] limit,
                                output bit to, output int unsigned ncyc);
    if (clen == 0) begin
      to = 1'b0; ncyc = 0;
      return;
    end
    to = 1'b1; ncyc = limit;
    for (int unsigned t = 0; t < trace.size(); t++) begin
      if (trace[t] == clen) begin
        to = 1'b0; ncyc = t + 1;
        break;
      end
    end
  endfunction

  task automatic run_job(input string tag, input vec_t v);
    logic [7:0]  bytes[$];
    int unsigned clen, nb, i, cyc, k;
    bit          valid, exp_we;
    clen = clamp_len(v.len);
    bytes.delete();
    bytes.push_back(v.len[7:0]);
    bytes.push_back(v.len[15:8]);
    for (int unsigned b = 0; b < 32'(v.len); b++) bytes.push_back(8'($urandom));
    nb = bytes.size();
    run_limit = v.limit;

    @(negedge clk);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'($urandom);
    #1;
    chk({tag, ".pre.rx_ready"}, 32'(rx_ready), 32'(0));
    chk({tag, ".pre.code_we"},  32'(code_we),  32'(0));

    i = 0; cyc = 0;
    while (i < nb) begin
      @(negedge clk);
      start    = v.sil ? 1'($urandom_range(1, 0)) : 1'b0;
      valid    = ($urandom_range(99, 0) >= v.gap);
      rx_valid = valid;
      rx_data  = valid ? bytes[i] : 8'($urandom);
      #1;
      if (cyc == 0) begin
        chk({tag, ".start.busy"},    32'(busy),    32'(1));
        chk({tag, ".start.done"},    32'(done),    32'(0));
        chk({tag, ".start.timeout"}, 32'(timeout), 32'(0));
      end
      chk({tag, ".ld.rx_ready"}, 32'(rx_ready),    32'(1));
      chk({tag, ".ld.core_rst"}, 32'(core_resetq), 32'(0));
      k      = i - 2;
      exp_we = valid && (i >= 2) && (k < clen);
      chk({tag, ".ld.code_we"}, 32'(code_we), 32'(exp_we));
      if (exp_we) begin
        chk({tag, ".ld.waddr"}, 32'(code_waddr), k);
        chk({tag, ".ld.wdata"}, 32'(code_wdata), 32'(bytes[i]));
      end
      if (valid) begin
        if (v.abort == 1 && i == nb / 2) begin
          do_abort({tag, ".abort_load"});
          return;
        end
        i++;
      end
      cyc++;
    end

    for (int unsigned j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      rx_valid = 1'($urandom); rx_data = 8'($urandom);
      start = ($urandom_range(7, 0) == 0);
      core_code_addr = CW'($urandom);
      rand_core();
      #1;
      chk({tag, ".clr.tape_wr"},   32'(tape_wr),     32'(1));
      chk({tag, ".clr.tape_addr"}, 32'(tape_addr),   j);
      chk({tag, ".clr.tape_dout"}, 32'(tape_dout),   32'(0));
      chk({tag, ".clr.rx_ready"},  32'(rx_ready),    32'(0));
      chk({tag, ".clr.core_rst"},  32'(core_resetq), 32'(0));
      chk({tag, ".clr.busy"},      32'(busy),        32'(1));
      if (v.abort == 2 && j == DEPTH / 2) begin
        do_abort({tag, ".abort_clear"});
        return;
      end
    end

    if (clen != 0) begin
      for (int unsigned t = 0; t < v.exp_cyc; t++) begin
        @(negedge clk);
        core_code_addr = CW'((t < trace.size()) ? trace[t] : 0);
        rand_core();
        rx_valid = v.rir ? 1'b1 : 1'($urandom);
        rx_data  = 8'($urandom);
        start    = ($urandom_range(7, 0) == 0);
        #1;
        chk({tag, ".run.core_rst"},  32'(core_resetq), 32'(1));
        chk({tag, ".run.tape_addr"}, 32'(tape_addr),   32'(core_mem_addr));
        chk({tag, ".run.tape_wr"},   32'(tape_wr),     32'(core_mem_wr));
        chk({tag, ".run.tape_dout"}, 32'(tape_dout),   32'(core_mem_dout));
        chk({tag, ".run.rx_ready"},  32'(rx_ready),    32'(0));
        chk({tag, ".run.code_we"},   32'(code_we),     32'(0));
        chk({tag, ".run.done"},      32'(done),        32'(0));
        chk({tag, ".run.cycles"},    cycles,           t);
        if (v.abort == 3 && t == v.exp_cyc / 2) begin
          do_abort({tag, ".abort_run"});
          return;
        end
      end
    end

    for (int unsigned d = 0; d < 2; d++) begin
      @(negedge clk);
      start = 1'b0; rx_valid = 1'($urandom); core_code_addr = '0;
      rand_core();
      #1;
      chk({tag, ".end.done"},      32'(done),        32'(1));
      chk({tag, ".end.busy"},      32'(busy),        32'(0));
      chk({tag, ".end.core_rst"},  32'(core_resetq), 32'(0));
      chk({tag, ".end.timeout"},   32'(timeout),     32'(v.exp_to));
      chk({tag, ".end.cycles"},    cycles,           v.exp_cyc);
      chk({tag, ".end.tape_wr"},   32'(tape_wr),     32'(0));
      chk({tag, ".end.tape_addr"}, 32'(tape_addr),   32'(0));
      chk({tag, ".end.rx_ready"},  32'(rx_ready),    32'(0));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t rv;
    bit   m_to;
    int unsigned m_cyc;

    //            len       limit   mode gap sil   rir   abort to    cyc
    tbl[0]  = '{16'd3,     32'd0,   0,   0,  1'b0, 1'b0, 0,  1'b0, 4};
    tbl[1]  = '{16'd0,     32'd0,   0,   0,  1'b0, 1'b0, 0,  1'b0, 0};
    tbl[2]  = '{16'd3,     32'd100, 1,   20, 1'b0, 1'b0, 0,  1'b1, 100};
    tbl[3]  = '{16'd255,   32'd256, 0,   0,  1'b0, 1'b0, 0,  1'b0, 256};
    tbl[4]  = '{16'd255,   32'd255, 0,   10, 1'b0, 1'b0, 0,  1'b1, 255};
    tbl[5]  = '{16'd256,   32'd0,   0,   0,  1'b0, 1'b0, 0,  1'b0, 256};
    tbl[6]  = '{16'h0400,  32'd0,   0,   0,  1'b1, 1'b1, 0,  1'b0, 256};
    tbl[7]  = '{16'd1,     32'd1,   0,   0,  1'b0, 1'b0, 0,  1'b1, 1};
    tbl[8]  = '{16'd2,     32'd0,   0,   0,  1'b0, 1'b0, 2,  1'b0, 3};
    tbl[9]  = '{16'd4,     32'd50,  1,   0,  1'b0, 1'b0, 3,  1'b1, 50};
    tbl[10] = '{16'd300,   32'd0,   0,   30, 1'b1, 1'b0, 1,  1'b0, 256};
    tbl[11] = '{16'd1,     32'd0,   0,   0,  1'b0, 1'b0, 0,  1'b0, 2};

    resetq = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    core_code_addr = '0; core_mem_addr = '0; core_mem_wr = 1'b0; core_mem_dout = '0;
    run_limit = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b1; rand_core();
    #1 check_reset_vals("por");
    resetq = 1'b1;

    for (int v = 0; v < 12; v++) begin
      build_trace(tbl[v].mode, clamp_len(tbl[v].len), tbl[v].limit);
      run_job($sformatf("vec%0d", v), tbl[v]);
    end

    for (int r = 0; r < 25; r++) begin
      rv.len   = 16'($urandom_range(320, 0));
      rv.limit = ($urandom_range(2, 0) == 0) ? 32'd0 : 32'($urandom_range(300, 1));
      rv.mode  = (rv.limit == 0) ? 0 : int'($urandom_range(2, 0));
      rv.gap   = int'($urandom_range(50, 0));
      rv.sil   = 1'($urandom);
      rv.rir   = 1'($urandom);
      rv.abort = 0;
      build_trace(rv.mode, clamp_len(rv.len), rv.limit);
      model(clamp_len(rv.len), rv.limit, m_to, m_cyc);
      rv.exp_to  = m_to;
      rv.exp_cyc = m_cyc;
      run_job($sformatf("rnd%0d", r), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
